// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access controller: request sizes and FSM states.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RDW  = 2'd1,
        WRW  = 2'd2,
        RSP  = 2'd3
    } state_t;

    // Illegal size or an address not aligned to the access size.
    function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: extracts a load value from a memory word and merges
// sub-word store data into a memory word. Purely combinational.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] rbuf,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = rbuf[31:24];
        half_lane  = offset[1] ? rbuf[15:0] : rbuf[31:16];
        load_data  = rbuf;
        store_word = wdata;

        // Offset 0 is the most significant lane.
        case (offset)
            2'd0: byte_lane = rbuf[31:24];
            2'd1: byte_lane = rbuf[23:16];
            2'd2: byte_lane = rbuf[15:8];
            2'd3: byte_lane = rbuf[7:0];
        endcase

        case (size)
            SZ_BYTE: begin
                load_data  = {{24{is_signed & byte_lane[7]}}, byte_lane};
                store_word = rbuf;
                case (offset)
                    2'd0: store_word[31:24] = wdata[7:0];
                    2'd1: store_word[23:16] = wdata[7:0];
                    2'd2: store_word[15:8]  = wdata[7:0];
                    2'd3: store_word[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data  = {{16{is_signed & half_lane[15]}}, half_lane};
                store_word = offset[1] ? {rbuf[31:16], wdata[15:0]}
                                       : {wdata[15:0], rbuf[15:0]};
            end
            default: begin
                load_data  = rbuf;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a big-endian byte-addressed data memory with active-low RD/WR.
// Optional range check enabled by defining MEM_ACCESS_BOUNDS_CHECK_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 128
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              RD,
    output logic              WR,
    output logic [ADDR_W-1:0] DAddr,
    output logic [31:0]       DataIn,
    input  logic [31:0]       DataOut,
    output state_t            dbg_state
);

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic        we_q;
    logic [31:0] wdata_q;

    logic        range_err;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    logic [ADDR_W:0] end_addr;
    assign end_addr  = {1'b0, req_addr[ADDR_W-1:2], 2'b00} + (ADDR_W+1)'(4);
    assign range_err = end_addr > (ADDR_W+1)'(MEM_BYTES);
`else
    assign range_err = 1'b0;
`endif

    assign req_err   = bad_shape(req_size, req_addr[1:0]) | range_err;
    assign req_ready = (state == IDLE);
    assign dbg_state = state;

    // DataOut is combinational from DAddr, so during RDW it is the word being modified.
    mem_lane_align u_align (
        .offset     (off_q),
        .size       (size_q),
        .is_signed  (sgn_q),
        .rbuf       (DataOut),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            off_q      <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            RD         <= 1'b1;
            WR         <= 1'b1;
            DAddr      <= '0;
            DataIn     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q   <= req_addr[1:0];
                        size_q  <= req_size;
                        sgn_q   <= req_signed;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RSP;
                        end else begin
                            resp_err <= 1'b0;
                            DAddr    <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_we && req_size == SZ_WORD) begin
                                WR     <= 1'b0;
                                DataIn <= req_wdata;
                                state  <= WRW;
                            end else begin
                                RD    <= 1'b0;
                                state <= RDW;
                            end
                        end
                    end
                end
                RDW: begin
                    RD <= 1'b1;
                    if (we_q) begin
                        WR     <= 1'b0;
                        DataIn <= store_word;
                        state  <= WRW;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= RSP;
                    end
                end
                WRW: begin
                    WR         <= 1'b1;
                    resp_rdata <= '0;
                    resp_valid <= 1'b1;
                    state      <= RSP;
                end
                RSP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, random traffic against a byte-array
// reference model, and a reset-during-write sequence.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    localparam int NBYTES = 128;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        RD;
    logic        WR;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    state_t      dbg_state;

    mem_access_ctrl #(.ADDR_W(32), .MEM_BYTES(NBYTES)) dut (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .RD(RD), .WR(WR), .DAddr(DAddr), .DataIn(DataIn),
        .DataOut(DataOut), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    // ---------------- memory attached to the DUT ----------------
    logic [7:0]  mem [NBYTES];
    logic [7:0]  ref_mem [NBYTES];
    int          wr_falls = 0;
    int          rd_falls = 0;
    int          resp_count = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always_comb begin
        DataOut = '0;
        for (int i = 0; i < 4; i++)
            if (DAddr + 32'(i) < 32'(NBYTES))
                DataOut[31-8*i -: 8] = mem[DAddr[6:0] + 7'(i)];
    end

    always @(negedge CLK) begin
        if (!RD) rd_falls++;
        if (resp_valid) resp_count++;
        if (!WR) begin
            wr_falls++;
            last_wr_addr = DAddr;
            last_wr_data = DataIn;
            for (int i = 0; i < 4; i++)
                if (DAddr + 32'(i) < 32'(NBYTES))
                    mem[DAddr[6:0] + 7'(i)] = DataIn[31-8*i -: 8];
        end
    end

    // ---------------- scoreboard bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            w = (w << 8) | ((a + 32'(i) < 32'(NBYTES)) ? 32'(ref_mem[a + 32'(i)]) : 32'd0);
        return w;
    endfunction

    function automatic void ref_access(input logic we, input logic [1:0] size, input logic sgn,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err,
                                       output int lat);
        int n;
        logic [31:0] v;
        n     = 1 << size;
        rdata = '0;
        err   = (size == 2'd3) || (addr % n != 0) ||
                (BOUNDS && ((addr & ~32'd3) + 4 > NBYTES));
        if (err) begin
            lat = 1;
            return;
        end
        lat = (we && n < 4) ? 3 : 2;
        if (we) begin
            for (int i = 0; i < n; i++)
                if (addr + 32'(i) < 32'(NBYTES))
                    ref_mem[addr + 32'(i)] = 8'(wdata >> (8 * (n - 1 - i)));
        end else begin
            v = '0;
            for (int i = 0; i < n; i++)
                v = (v << 8) | ((addr + 32'(i) < 32'(NBYTES)) ? 32'(ref_mem[addr + 32'(i)]) : 32'd0);
            if (sgn && n < 4 && v[8*n-1])
                v = v | ~((32'd1 << (8 * n)) - 1);
            rdata = v;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge CLK);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit has_tbl, input logic [31:0] t_rdata, input logic t_err);
        logic [31:0] m_rdata, d_rdata;
        logic        m_err, d_err;
        int          m_lat, d_lat, wr0, rd0;
        ref_access(we, size, sgn, addr, wdata, m_rdata, m_err, m_lat);
        wr0 = wr_falls;
        rd0 = rd_falls;
        do_req(we, size, sgn, addr, wdata, d_rdata, d_err, d_lat);
        check("resp_rdata", d_rdata, m_rdata);
        check("resp_err", 32'(d_err), 32'(m_err));
        check("latency", 32'(d_lat), 32'(m_lat));
        check("wr_low_edges", 32'(wr_falls - wr0), (we && !m_err) ? 32'd1 : 32'd0);
        check("rd_low_edges", 32'(rd_falls - rd0),
              (!m_err && (!we || size != SZ_WORD)) ? 32'd1 : 32'd0);
        if (we && !m_err) begin
            check("wr_daddr", last_wr_addr, addr & ~32'd3);
            check("wr_datain", last_wr_data, ref_word(addr & ~32'd3));
        end
        if (has_tbl) begin
            check("tbl_rdata", d_rdata, t_rdata);
            check("tbl_err", 32'(d_err), 32'(t_err));
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int mism, base_wr, base_resp;
        logic [1:0]  sz;
        logic [31:0] a;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h12345678, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000078, 1'b0};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1234BEEF, 1'b0};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h00001234, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h10, 32'hFFFFFF80, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000080, 1'b0};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h0, 1'b1};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h13, 32'h0000AAAA, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0, 1'b1};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h7C, 32'hCAFEF00D, 32'h0, 1'b0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h7C, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h80, 32'h0,        32'h0, BOUNDS};

        for (int i = 0; i < NBYTES; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // reset state
        #12;
        check("rst_RD", 32'(RD), 32'd1);
        check("rst_WR", 32'(WR), 32'd1);
        check("rst_DAddr", DAddr, 32'h0);
        check("rst_DataIn", DataIn, 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;

        for (int i = 0; i < 16; i++)
            run_txn(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    1'b1, vecs[i].exp_rdata, vecs[i].exp_err);

        for (int i = 0; i < 150; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                a = a & ~((32'd1 << sz) - 1);
            run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, 32'h0, 1'b0);
        end

        // reset asserted while the word write is pending, before its falling edge
        @(negedge CLK);
        base_wr    = wr_falls;
        base_resp  = resp_count;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = SZ_WORD;
        req_addr   = 32'h20;
        req_wdata  = 32'hDEADBEEF;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        check("wrw_WR_low", 32'(WR), 32'd0);
        Reset = 1'b1;
        #1;
        check("rst_wrw_WR", 32'(WR), 32'd1);
        check("rst_wrw_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_wrw_ready", 32'(req_ready), 32'd1);
        check("rst_wrw_no_write", 32'(wr_falls - base_wr), 32'd0);
        @(negedge CLK);
        check("rst_wrw_no_resp", 32'(resp_count - base_resp), 32'd0);
        check("rst_wrw_mem", {mem[32], mem[33], mem[34], mem[35]}, ref_word(32'h20));

        mism = 0;
        for (int i = 0; i < NBYTES; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        check("final_mem_bytes_differing", 32'(mism), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory initiator between the multi-cycle CPU datapath and the byte-addressed, big-endian data memory.
- Accepts load/store requests of byte, halfword or word size, checks alignment and issues word-aligned memory cycles.
- Memory control pins are active-low: RD, and WR, which writes on the falling edge of CLK.
- Sub-word stores use read-modify-write. Load data is extracted and sign/zero-extended, and the result is returned with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, width of request and memory address.
- MEM_BYTES, 128, data memory size in bytes; used only under the optional feature.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 halfword, 2 word; 3 is illegal.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; misaligned, illegal size, or out of range.
- RD  out  1  memory read enable, active low.
- WR  out  1  memory write enable, active low.
- DAddr  out  ADDR_W  word-aligned memory address (bits [1:0] always 0).
- DataIn  out  32  memory write data.
- DataOut  in  32  memory read data; combinational from DAddr.

Behaviour:
- Clocking and reset:
  - One clock, CLK. Reset is asynchronous and active-high.
  - Reset forces IDLE immediately: RD=1, WR=1, DAddr=0, DataIn=0, resp_valid=0, resp_rdata=0, resp_err=0, all internal registers 0.
  - Reset during WRW raises WR at once, so no write occurs on the following falling edge. The pending request is dropped and no response is issued.
- Request capture: a request is accepted on a rising edge with req_valid && req_ready. Address, size, signed, we and wdata are latched; later request inputs are ignored until IDLE.
- Error check at accept:
  - Illegal size (3), halfword with addr[0]=1, or word with addr[1:0]!=0 sets err.
  - An error request goes IDLE -> RSP with resp_err=1 and no memory cycle; WR and RD stay 1.
- States:
  - IDLE: req_ready=1.
  - RDW: RD=0, DAddr={addr[ADDR_W-1:2],2'b00}. DataOut is latched into rbuf on the exiting rising edge.
  - WRW: WR=0, DAddr aligned, DataIn = merged word. Held exactly one full cycle, so exactly one falling edge sees WR=0.
  - RSP: resp_valid=1 for one cycle, then IDLE. resp_rdata and resp_err are valid only here.
- Transitions from IDLE:
  - Load: RDW -> RSP.
  - Word store: WRW -> RSP.
  - Byte or halfword store: RDW -> WRW -> RSP.
- Latency from the accept edge: load and word store show resp_valid in the 2nd cycle; sub-word store in the 3rd. Minimum request spacing equals latency + 1, since req_ready is low during RSP.
- Big-endian lane mapping: byte offset 0 maps to bits [31:24] and offset 3 to bits [7:0]. Halfword offset 0 maps to [31:16], offset 2 to [15:0].
- Load extraction: the selected lane is right-justified. It is sign-extended from bit 7 or bit 15 when req_signed=1, otherwise zero-extended. Word loads pass through unchanged.
- Store merge: rbuf with the selected lane replaced by wdata[7:0] or wdata[15:0]. Word stores use wdata directly.
- Outside active states: RD=1, WR=1, and DAddr/DataIn hold their last values.

Optional Feature:
- Macro MEM_ACCESS_BOUNDS_CHECK_EN.
- Defined: an aligned address with {addr[ADDR_W-1:2],2'b00} + 4 > MEM_BYTES is flagged as an error at accept. It takes the error path: no RD/WR, resp_err=1.
- Undefined: no range check; DAddr is driven from any aligned address and MEM_BYTES is unused.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - the state enum IDLE/RDW/WRW/RSP.
- Sub-module mem_lane_align, purely combinational:
  - inputs: offset, size, signed, rbuf, wdata;
  - outputs: extracted load value and merged store word;
  - reused by both the load and store paths.

Test Plan:
- Store word 0x12345678 at addr 0x10, then load word at 0x10 -> WR low for exactly 1 cycle with DAddr=0x10, DataIn=0x12345678; load resp_rdata=0x12345678, resp_err=0, resp_valid 2 cycles after accept.
- With word 0x12345678 at 0x10: signed byte load at 0x13 -> 0x00000078. Signed byte load at 0x10 after storing 0x80 to byte 0x10 -> 0xFFFFFF80. Unsigned -> 0x00000080.
- Halfword store 0xBEEF at 0x12 over 0x12345678 -> RDW then WRW with DataIn=0x1234BEEF. Subsequent word load returns 0x1234BEEF; resp_valid 3 cycles after accept.
- Word load at 0x11, halfword store at 0x13, size=3 -> resp_err=1, resp_rdata=0, RD and WR never low, memory unchanged.
- Assert Reset during WRW before the falling edge -> WR=1 immediately, memory word unchanged, no resp_valid, req_ready=1 after release.
- MEM_ACCESS_BOUNDS_CHECK_EN defined: word load at 0x80 (MEM_BYTES=128) -> resp_err=1 with no RD. Load at 0x7C -> normal response. Undefined: 0x80 -> resp_err=0.
